decmpp_recon: RTL and testbench
===============================

# decmpp_recon

Parametrised midpoint-prediction (MPP) reconstruction for the VDC-M decoder. It accepts one 2-row block of quantised residuals per transfer for any of `NUM_COMP` components, dequantises by the block's step size, and adds the per-subblock midpoint. The result is clipped to the sample range and output. Per-component subblock means are stored and updated so that the next block of the same component predicts from them; the block sits between entropy decode and the reconstruction buffer.

## Interface
Parameters:
- `BIT_DEPTH`, 8: sample bit depth; `middle` = 1<<(BIT_DEPTH-1), `maxVal` = (1<<BIT_DEPTH)-1
- `NUM_COMP`, 3: number of components with independent mean state
- `BLK_W`, 8: block width (even); block is BLK_W x 2, `NS` = 2*BLK_W samples, `NSB` = BLK_W/2 subblocks
- `RES_W`, 8: signed residual width
- `STEP_W`, 4: step-size width

Ports:
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `in_vld` in 1: input block valid
- `in_rdy` out 1: input ready
- `in_first` in 1: first block of slice; forces mean = `middle` for this block
- `in_comp` in clog2(NUM_COMP): component index
- `in_step` in STEP_W: step size, legal range 0..BIT_DEPTH-1
- `in_res` in NS*RES_W: signed residuals, sample i at bits [i*RES_W +: RES_W], raster order
- `out_vld` out 1: output valid
- `out_rdy` in 1: downstream ready
- `out_comp` out clog2(NUM_COMP): component of output block
- `out_rec` out NS*BIT_DEPTH: reconstructed samples, same ordering
- `out_clip` out NS: per-sample clip flag (only with `DECMPP_CLIP_FLAG_EN`)

## Operation
- Two-register pipeline:
  - S0 captures input on `in_vld && in_rdy`.
  - S1 is the output register.
  - S0→S1 transfer occurs when S0 is valid and S1 is empty or draining (`!out_vld || out_rdy`).
- `in_rdy` = !S0.vld || S0 transfers this cycle.
- Subblock k = samples {2k, 2k+1, BLK_W+2k, BLK_W+2k+1}.
- Midpoint computation (combinational from S0):
  - bias = step==0 ? 0 : 1<<(step-1)
  - maxClip = min(maxVal, middle+2*bias)
  - meanUse[k] = S0.first ? middle : mean[comp][k]
  - mp[k] = clip3(middle, maxClip, meanUse[k]+2*bias)
- Reconstruction:
  - deq = sign-extended res << step, computed at RES_W+BIT_DEPTH+1 bits signed
  - rec = clip3(0, maxVal, deq + mp[k])
  - clip flag = 1 when clipping was applied
- Mean update: on S0→S1 transfer, mean[comp][k] <= (sum of subblock k's four rec values) >> 2, floor, BIT_DEPTH+2-bit sum. The update happens in the same edge as the transfer, so a back-to-back block of the same component sees the updated mean.
- Other components' means are untouched.
- `in_first` with any comp affects only that block's prediction; the stored mean is still overwritten by that block's result.

## Timing
- Latency: block accepted at edge N → `out_vld` high after edge N+1 (two-register pipeline); throughput 1 block/cycle.
- `out_rec`, `out_comp`, and `out_clip` are held stable while `out_vld && !out_rdy`.
- Output stall: S0 holds; `in_rdy` low while S0 is full and S1 is stalled. No data is dropped or duplicated.
- Reset values:
  - `out_vld`=0, `out_rec`=0, `out_comp`=0, `out_clip`=0
  - S0 invalid; `in_rdy`=1 from the first edge after reset deassertion
  - all mean[c][k] = `middle`
- Reset mid-operation: in-flight blocks are discarded; means return to `middle`.
- Simultaneous accept and transfer: legal; S0 refills in the same edge.

## Configuration
- `DECMPP_CLIP_FLAG_EN` defined: `out_clip` port exists and is registered in S1 with `out_rec`.
- Undefined: port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `decmpp_pkg`:
  - `clip3` function (min, max, value)
  - `middle`/`maxVal`/bias helper functions of bit depth and step
  - subblock index mapping function
- One sub-module `decmpp_mp_calc`: given mean, step, first → mp for one subblock; instantiated NSB times.
- Mean storage is a NUM_COMP x NSB register array in `decmpp_recon`.

## Test plan
All scenarios use BIT_DEPTH=8, NUM_COMP=3, BLK_W=8.
- First block of slice: comp0, first=1, step=2, all res=1 → mp=132, all rec=136, no clip.
- Back-to-back same component: comp0 again next cycle, first=0, step=2, res=0 → mean 136, mp=clip(128,132,140)=132, rec=132.
- Clipping at both ends: comp1 first=1, step=2, res sample0=-40, sample1=+40, rest 0 → rec0=0 (clip), rec1=255 (clip), rest=132.
- Step 0: res=5, first=1 → bias 0, maxClip=128, mp=128, rec=133.
- Component independence: comp0 blocks interleaved with comp2 first=1 blocks → comp0 means are unaffected by comp2 results.
- Backpressure and reset: `out_rdy` low for 4 cycles during streaming → `in_rdy` drops after two accepts, output order preserved. `rst` pulse mid-stream → `out_vld`=0 immediately, the next first=0 block predicts from mean 128.

Source files
------------

// File: rtl/decmpp_pkg.sv
// Shared helpers for VDC-M midpoint-prediction reconstruction: sample-range
// constants, midpoint bias, clipping and subblock index mapping.
package decmpp_pkg;

    function automatic int clip3(input int lo, input int hi, input int v);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int middle_of(input int bit_depth);
        return 1 << (bit_depth - 1);
    endfunction

    function automatic int max_val_of(input int bit_depth);
        return (1 << bit_depth) - 1;
    endfunction

    function automatic int bias_of(input int step);
        return (step == 0) ? 0 : (1 << (step - 1));
    endfunction

    // Raster sample index -> subblock; a subblock is a 2x2 tile across both rows.
    function automatic int sb_of(input int idx, input int blk_w);
        return (idx % blk_w) / 2;
    endfunction

endpackage

// File: rtl/decmpp_mp_calc.sv
// Midpoint predictor for one subblock: biased mean clipped into
// [middle, min(maxVal, middle + 2*bias)].
module decmpp_mp_calc
    import decmpp_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int STEP_W    = 4
) (
    input  logic [BIT_DEPTH-1:0] mean,
    input  logic [STEP_W-1:0]    step,
    input  logic                 first,
    output logic [BIT_DEPTH-1:0] mp
);

    localparam int MIDDLE  = middle_of(BIT_DEPTH);
    localparam int MAX_VAL = max_val_of(BIT_DEPTH);

    logic signed [31:0] bias2;
    logic signed [31:0] max_clip;
    logic signed [31:0] mean_use;

    always_comb begin
        bias2    = 2 * bias_of(int'(step));
        max_clip = clip3(0, MAX_VAL, MIDDLE + bias2);
        mean_use = first ? MIDDLE : int'(mean);
        mp       = BIT_DEPTH'(clip3(MIDDLE, max_clip, mean_use + bias2));
    end

endmodule

// File: rtl/decmpp_recon.sv
// MPP reconstruction: dequantise residuals, add per-subblock midpoint, clip,
// and keep per-component subblock means. Optional out_clip via DECMPP_CLIP_FLAG_EN.
module decmpp_recon
    import decmpp_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int NUM_COMP  = 3,
    parameter int BLK_W     = 8,
    parameter int RES_W     = 8,
    parameter int STEP_W    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_vld,
    output logic                              in_rdy,
    input  logic                              in_first,
    input  logic [$clog2(NUM_COMP)-1:0]       in_comp,
    input  logic [STEP_W-1:0]                 in_step,
    input  logic [2*BLK_W*RES_W-1:0]          in_res,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [$clog2(NUM_COMP)-1:0]       out_comp,
    output logic [2*BLK_W*BIT_DEPTH-1:0]      out_rec
`ifdef DECMPP_CLIP_FLAG_EN
    ,
    output logic [2*BLK_W-1:0]                out_clip
`endif
);

    localparam int NS      = 2 * BLK_W;
    localparam int NSB     = BLK_W / 2;
    localparam int CW      = $clog2(NUM_COMP);
    localparam int DEQ_W   = RES_W + BIT_DEPTH + 1;
    localparam int SUM_W   = BIT_DEPTH + 2;
    localparam int MAX_VAL = max_val_of(BIT_DEPTH);
    localparam logic [BIT_DEPTH-1:0] MIDDLE = BIT_DEPTH'(middle_of(BIT_DEPTH));

    logic                    s0_vld_q, s0_vld_d;
    logic                    s0_first_q, s0_first_d;
    logic [CW-1:0]           s0_comp_q, s0_comp_d;
    logic [STEP_W-1:0]       s0_step_q, s0_step_d;
    logic [NS*RES_W-1:0]     s0_res_q, s0_res_d;

    logic                    out_vld_q, out_vld_d;
    logic [CW-1:0]           out_comp_q, out_comp_d;
    logic [NS*BIT_DEPTH-1:0] out_rec_q, out_rec_d;

    logic [BIT_DEPTH-1:0]    mean_q [NUM_COMP][NSB];
    logic [BIT_DEPTH-1:0]    mean_d [NUM_COMP][NSB];

    logic                    xfer;
    logic                    accept;
    logic [BIT_DEPTH-1:0]    mp       [NSB];
    logic signed [DEQ_W-1:0] deq      [NS];
    logic signed [31:0]      sum      [NS];
    logic [BIT_DEPTH-1:0]    rec      [NS];
    logic [SUM_W-1:0]        msum     [NSB];
    logic [BIT_DEPTH-1:0]    mean_new [NSB];
    logic [NS*BIT_DEPTH-1:0] rec_flat;

`ifdef DECMPP_CLIP_FLAG_EN
    logic [NS-1:0]           clip;
    logic [NS-1:0]           out_clip_q, out_clip_d;
`endif

    for (genvar g = 0; g < NSB; g++) begin : g_mp
        decmpp_mp_calc #(
            .BIT_DEPTH(BIT_DEPTH),
            .STEP_W   (STEP_W)
        ) u_mp (
            .mean (mean_q[s0_comp_q][g]),
            .step (s0_step_q),
            .first(s0_first_q),
            .mp   (mp[g])
        );
    end

    always_comb begin
        rec_flat = '0;
`ifdef DECMPP_CLIP_FLAG_EN
        clip = '0;
`endif
        for (int unsigned i = 0; i < NS; i++) begin
            deq[i] = DEQ_W'($signed(s0_res_q[i*RES_W +: RES_W])) <<< s0_step_q;
            sum[i] = int'(deq[i]) + int'(mp[sb_of(int'(i), BLK_W)]);
            rec[i] = BIT_DEPTH'(clip3(0, MAX_VAL, sum[i]));
            rec_flat[i*BIT_DEPTH +: BIT_DEPTH] = rec[i];
`ifdef DECMPP_CLIP_FLAG_EN
            clip[i] = (sum[i] < 0) || (sum[i] > MAX_VAL);
`endif
        end
        for (int unsigned k = 0; k < NSB; k++) begin
            msum[k] = SUM_W'(rec[2*k]) + SUM_W'(rec[2*k+1])
                    + SUM_W'(rec[BLK_W+2*k]) + SUM_W'(rec[BLK_W+2*k+1]);
            mean_new[k] = BIT_DEPTH'(msum[k] >> 2);
        end
    end

    always_comb begin
        xfer   = s0_vld_q && (!out_vld_q || out_rdy);
        in_rdy = !s0_vld_q || xfer;
        accept = in_vld && in_rdy;

        s0_vld_d   = s0_vld_q;
        s0_first_d = s0_first_q;
        s0_comp_d  = s0_comp_q;
        s0_step_d  = s0_step_q;
        s0_res_d   = s0_res_q;
        if (accept) begin
            s0_vld_d   = 1'b1;
            s0_first_d = in_first;
            s0_comp_d  = in_comp;
            s0_step_d  = in_step;
            s0_res_d   = in_res;
        end else if (xfer) begin
            s0_vld_d = 1'b0;
        end

        out_vld_d  = out_vld_q;
        out_comp_d = out_comp_q;
        out_rec_d  = out_rec_q;
`ifdef DECMPP_CLIP_FLAG_EN
        out_clip_d = out_clip_q;
`endif
        mean_d = mean_q;
        // Mean written on the transfer edge so a back-to-back block of the same comp sees it.
        if (xfer) begin
            out_vld_d  = 1'b1;
            out_comp_d = s0_comp_q;
            out_rec_d  = rec_flat;
`ifdef DECMPP_CLIP_FLAG_EN
            out_clip_d = clip;
`endif
            for (int unsigned k = 0; k < NSB; k++) begin
                mean_d[s0_comp_q][k] = mean_new[k];
            end
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld_q   <= 1'b0;
            s0_first_q <= 1'b0;
            s0_comp_q  <= '0;
            s0_step_q  <= '0;
            s0_res_q   <= '0;
            out_vld_q  <= 1'b0;
            out_comp_q <= '0;
            out_rec_q  <= '0;
`ifdef DECMPP_CLIP_FLAG_EN
            out_clip_q <= '0;
`endif
            for (int unsigned c = 0; c < NUM_COMP; c++) begin
                for (int unsigned k = 0; k < NSB; k++) begin
                    mean_q[c][k] <= MIDDLE;
                end
            end
        end else begin
            s0_vld_q   <= s0_vld_d;
            s0_first_q <= s0_first_d;
            s0_comp_q  <= s0_comp_d;
            s0_step_q  <= s0_step_d;
            s0_res_q   <= s0_res_d;
            out_vld_q  <= out_vld_d;
            out_comp_q <= out_comp_d;
            out_rec_q  <= out_rec_d;
`ifdef DECMPP_CLIP_FLAG_EN
            out_clip_q <= out_clip_d;
`endif
            mean_q     <= mean_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_comp = out_comp_q;
    assign out_rec  = out_rec_q;
`ifdef DECMPP_CLIP_FLAG_EN
    assign out_clip = out_clip_q;
`endif

endmodule

// File: tb/tb_decmpp_recon.sv
// Bench for decmpp_recon: directed scenarios plus randomized traffic checked
// against an arithmetic reference model and in-order scoreboard.
module tb_decmpp_recon;

    localparam int BD   = 8;
    localparam int NC   = 3;
    localparam int BW   = 8;
    localparam int RW   = 8;
    localparam int SW   = 4;
    localparam int NS   = 2 * BW;
    localparam int NSB  = BW / 2;
    localparam int W    = NS * BD;
    localparam int RWS  = NS * RW;
    localparam int MIDV = 128;
    localparam int MAXV = 255;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_vld;
    logic           in_rdy;
    logic           in_first;
    logic [1:0]     in_comp;
    logic [SW-1:0]  in_step;
    logic [RWS-1:0] in_res;
    logic           out_vld;
    logic           out_rdy;
    logic [1:0]     out_comp;
    logic [W-1:0]   out_rec;
`ifdef DECMPP_CLIP_FLAG_EN
    logic [NS-1:0]  out_clip;
`endif

    always #5 clk = ~clk;

    decmpp_recon #(
        .BIT_DEPTH(BD),
        .NUM_COMP (NC),
        .BLK_W    (BW),
        .RES_W    (RW),
        .STEP_W   (SW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_first(in_first),
        .in_comp (in_comp),
        .in_step (in_step),
        .in_res  (in_res),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_comp(out_comp),
        .out_rec (out_rec)
`ifdef DECMPP_CLIP_FLAG_EN
        ,
        .out_clip(out_clip)
`endif
    );

    typedef struct {
        logic [1:0]    comp;
        logic [W-1:0]  rec;
        logic [NS-1:0] clip;
    } exp_t;

    exp_t          sb_q[$];
    logic [W-1:0]  got_q[$];
    int            mean_m [NC][NSB];
    int            n_err = 0;
    int            n_chk = 0;
    int            n_acc = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            pop_cyc = 0;
    bit            stall_pend = 1'b0;
    logic [W-1:0]  held_rec;
    logic [1:0]    held_comp;
    logic [W-1:0]  last_rec;
    logic [NS-1:0] last_clip;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NSB; k++)
                mean_m[c][k] = MIDV;
    endtask

    // Reference: dequantise by multiplication, predict from stored means, clamp, refresh means.
    function automatic exp_t ref_block(input int comp, input bit first, input int step,
                                       input logic [RWS-1:0] res);
        exp_t e;
        int bias, max_clip, mu, mp, v, k;
        int acc [NSB];
        logic signed [RW-1:0] r;
        bias     = (step == 0) ? 0 : (1 << (step - 1));
        max_clip = (MIDV + 2 * bias > MAXV) ? MAXV : MIDV + 2 * bias;
        for (int j = 0; j < NSB; j++) acc[j] = 0;
        e.comp = 2'(comp);
        e.rec  = '0;
        e.clip = '0;
        for (int i = 0; i < NS; i++) begin
            k  = (i % BW) / 2;
            mu = first ? MIDV : mean_m[comp][k];
            mp = mu + 2 * bias;
            if (mp > max_clip) mp = max_clip;
            if (mp < MIDV) mp = MIDV;
            r = res[i*RW +: RW];
            v = int'(r) * (1 << step) + mp;
            if (v < 0) begin
                v = 0;
                e.clip[i] = 1'b1;
            end else if (v > MAXV) begin
                v = MAXV;
                e.clip[i] = 1'b1;
            end
            e.rec[i*BD +: BD] = BD'(v);
            acc[k] += v;
        end
        for (int j = 0; j < NSB; j++) mean_m[comp][j] = acc[j] / 4;
        return e;
    endfunction

    function automatic logic [RWS-1:0] rep_res(input int v);
        logic [RWS-1:0] r;
        for (int i = 0; i < NS; i++) r[i*RW +: RW] = RW'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] rep_rec(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < NS; i++) r[i*BD +: BD] = BD'(v);
        return r;
    endfunction

    function automatic logic [RWS-1:0] rand_res();
        logic [RWS-1:0] r;
        for (int i = 0; i < NS; i++)
            r[i*RW +: RW] = ($urandom_range(0, 3) == 0) ? RW'($urandom)
                                                        : RW'(int'($urandom_range(0, 8)) - 4);
        return r;
    endfunction

    function automatic logic [W-1:0] nth_got(input int i);
        if (got_q.size() > i) return got_q[i];
        return 'x;
    endfunction

    task automatic set_in(input int comp, input bit first, input int step, input logic [RWS-1:0] res);
        in_comp  = 2'(comp);
        in_first = first;
        in_step  = SW'(step);
        in_res   = res;
    endtask

    task automatic set_rand_in();
        set_in(int'($urandom_range(0, NC - 1)), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, BD - 1)), rand_res());
    endtask

    // One clock: scoreboard handshakes that the next rising edge will perform.
    task automatic cycle();
        exp_t e;
        #1;
        if (stall_pend) begin
            check_eq("hold_vld", W'(out_vld), W'(1));
            check_eq("hold_rec", out_rec, held_rec);
            check_eq("hold_comp", W'(out_comp), W'(held_comp));
            stall_pend = 1'b0;
        end
        if (out_vld && out_rdy) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out", W'(out_vld), W'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("out_rec", out_rec, e.rec);
                check_eq("out_comp", W'(out_comp), W'(e.comp));
`ifdef DECMPP_CLIP_FLAG_EN
                check_eq("out_clip", W'(out_clip), W'(e.clip));
                last_clip = out_clip;
`endif
                last_rec = out_rec;
                got_q.push_back(out_rec);
                pop_cyc = cyc;
            end
        end else if (out_vld) begin
            stall_pend = 1'b1;
            held_rec   = out_rec;
            held_comp  = out_comp;
        end
        if (in_vld && in_rdy) begin
            sb_q.push_back(ref_block(int'(in_comp), in_first, int'(in_step), in_res));
            n_acc++;
            acc_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_one(input int comp, input bit first, input int step, input logic [RWS-1:0] res);
        int a;
        a         = n_acc;
        last_rec  = 'x;
        last_clip = 'x;
        set_in(comp, first, step, res);
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        for (int t = 0; t < 8 && n_acc == a; t++) cycle();
        in_vld = 1'b0;
        for (int t = 0; t < 8 && sb_q.size() != 0; t++) cycle();
        check_eq("run_drained", W'(sb_q.size()), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]   exp_v;
        logic [RWS-1:0] res_v;
        int a;

        reset_model();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        set_in(0, 1'b0, 0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_vld", W'(out_vld), W'(0));
        check_eq("rst_out_rec", out_rec, '0);
        check_eq("rst_out_comp", W'(out_comp), W'(0));
`ifdef DECMPP_CLIP_FLAG_EN
        check_eq("rst_out_clip", W'(out_clip), W'(0));
`endif
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_rdy", W'(in_rdy), W'(1));

        run_one(0, 1'b1, 2, rep_res(1));
        check_eq("first_blk_rec", last_rec, rep_rec(136));
        check_eq("latency", W'(pop_cyc - acc_cyc), W'(2));

        got_q.delete();
        a = n_acc;
        set_in(0, 1'b1, 2, rep_res(1));
        in_vld = 1'b1;
        cycle();
        set_in(0, 1'b0, 2, rep_res(0));
        cycle();
        in_vld = 1'b0;
        repeat (4) cycle();
        check_eq("b2b_accepts", W'(n_acc - a), W'(2));
        check_eq("b2b_rec0", nth_got(0), rep_rec(136));
        check_eq("b2b_rec1", nth_got(1), rep_rec(132));

        res_v = rep_res(0);
        res_v[RW-1:0]    = RW'(-40);
        res_v[2*RW-1:RW] = RW'(40);
        run_one(1, 1'b1, 2, res_v);
        exp_v = rep_rec(132);
        exp_v[BD-1:0]    = '0;
        exp_v[2*BD-1:BD] = '1;
        check_eq("clip_rec", last_rec, exp_v);
`ifdef DECMPP_CLIP_FLAG_EN
        check_eq("clip_flags", W'(last_clip), W'(3));
`endif

        run_one(2, 1'b1, 0, rep_res(5));
        check_eq("step0_rec", last_rec, rep_rec(133));

        run_one(2, 1'b1, 2, rep_res(-20));
        check_eq("comp2_low_rec", last_rec, rep_rec(52));
        run_one(0, 1'b0, 3, rep_res(0));
        check_eq("comp_indep_rec", last_rec, rep_rec(136));

        out_rdy = 1'b0;
        a = n_acc;
        repeat (4) begin
            set_rand_in();
            in_vld = 1'b1;
            cycle();
        end
        check_eq("bp_accepts", W'(n_acc - a), W'(2));
        check_eq("bp_in_rdy", W'(in_rdy), W'(0));
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (5) cycle();
        check_eq("bp_drained", W'(sb_q.size()), W'(0));

        run_one(0, 1'b1, 2, rep_res(-20));
        check_eq("low_mean_rec", last_rec, rep_rec(52));
        set_in(1, 1'b0, 3, rand_res());
        in_vld = 1'b1;
        repeat (2) cycle();
        rst    = 1'b1;
        in_vld = 1'b0;
        #1;
        check_eq("midrst_out_vld", W'(out_vld), W'(0));
        check_eq("midrst_out_rec", out_rec, '0);
        sb_q.delete();
        reset_model();
        stall_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_one(0, 1'b0, 2, rep_res(0));
        check_eq("post_rst_rec", last_rec, rep_rec(132));

        for (int n = 0; n < 400; n++) begin
            set_rand_in();
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int t = 0; t < 10 && sb_q.size() != 0; t++) cycle();
        check_eq("final_drain", W'(sb_q.size()), W'(0));
        cycle();
        check_eq("final_out_vld", W'(out_vld), W'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
